// File: rtl/otg_hpi_master.sv
// ---------------------------------------------------------------------------
// otg_hpi_master
//
// Hardware HPI bus master for the CY7C67200 OTG controller. Each Avalon-MM
// read or write is turned into one timed HPI cycle (setup, strobe, hold,
// recover). The Avalon master is stalled with waitrequest until the HPI
// cycle has finished. The asynchronous otg_int line is passed through a
// two-flop synchroniser and presented as irq.
//
// Ports
//   clk, reset_n             system clock, asynchronous active-low reset
//   address[1:0]             HPI register (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
//   chipselect, read, write  Avalon request qualifiers (write wins over read)
//   writedata[31:0]          write data, only [15:0] reaches the HPI bus
//   readdata[31:0]           {16'b0, last sampled HPI read data}
//   waitrequest              Avalon stall, combinational
//   irq                      synchronised otg_int
//   otg_addr, otg_cs_n,
//   otg_rd_n, otg_wr_n       HPI address and active-low control pins
//   otg_data_out, otg_data_oe  HPI write data and its tristate enable
//   otg_data_in              HPI read data
//   otg_int                  HPI interrupt, asynchronous
// ---------------------------------------------------------------------------
module otg_hpi_master #(
   parameter int SETUP_CYC   = 1,
   parameter int STROBE_CYC  = 2,
   parameter int HOLD_CYC    = 1,
   parameter int RECOVER_CYC = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic        irq,
   output logic [1:0]  otg_addr,
   output logic        otg_cs_n,
   output logic        otg_rd_n,
   output logic        otg_wr_n,
   output logic [15:0] otg_data_out,
   output logic        otg_data_oe,
   input  logic [15:0] otg_data_in,
   input  logic        otg_int
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      RECOVER = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Each phase counter is loaded with (length - 1) on entry and the phase
   // ends on the clock where it reads zero.
   localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
   localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [7:0]  cnt_r;
   logic [7:0]  cnt_nxt_s;
   logic        op_wr_r;
   logic        op_wr_nxt_s;
   logic        req_s;
   logic        latch_s;
   logic        capture_s;
   logic        active_nxt_s;
   logic        cs_n_nxt_s;
   logic        rd_n_nxt_s;
   logic        wr_n_nxt_s;
   logic        oe_nxt_s;
   logic        int_meta_r;
   logic        unused_wdata_s;

   // Upper write data half never reaches the 16-bit HPI bus.
   assign unused_wdata_s = ^writedata[31:16];

   assign req_s       = chipselect & (read | write);
   assign waitrequest = req_s & (state_r != DONE);

   // Next-state, phase counter and next values of the registered HPI pins.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r - 8'd1;
      op_wr_nxt_s = op_wr_r;
      latch_s     = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               state_nxt_s = SETUP;
               cnt_nxt_s   = SETUP_LD;
               op_wr_nxt_s = write;
               latch_s     = 1'b1;
            end else begin
               cnt_nxt_s   = 8'd0;
            end
         end
         SETUP: begin
            if (cnt_r == 8'd0) begin
               state_nxt_s = STROBE;
               cnt_nxt_s   = STROBE_LD;
            end else begin
               state_nxt_s = SETUP;
            end
         end
         STROBE: begin
            if (cnt_r == 8'd0) begin
               state_nxt_s = HOLD;
               cnt_nxt_s   = HOLD_LD;
               capture_s   = ~op_wr_r;
            end else begin
               state_nxt_s = STROBE;
            end
         end
         HOLD: begin
            if (cnt_r == 8'd0) begin
               state_nxt_s = RECOVER;
               cnt_nxt_s   = RECOVER_LD;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         RECOVER: begin
            if (cnt_r == 8'd0) begin
               state_nxt_s = DONE;
               cnt_nxt_s   = 8'd0;
            end else begin
               state_nxt_s = RECOVER;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 8'd0;
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 8'd0;
         end
      endcase

      // Pins are decoded from the next state so the registered outputs line
      // up exactly with the state they belong to.
      active_nxt_s = (state_nxt_s == SETUP) || (state_nxt_s == STROBE) ||
                     (state_nxt_s == HOLD);
      cs_n_nxt_s   = ~active_nxt_s;
      rd_n_nxt_s   = ~((state_nxt_s == STROBE) & ~op_wr_nxt_s);
      wr_n_nxt_s   = ~((state_nxt_s == STROBE) &  op_wr_nxt_s);
      oe_nxt_s     = active_nxt_s & op_wr_nxt_s;
   end

   // FSM state, latched request and registered HPI pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         cnt_r        <= 8'd0;
         op_wr_r      <= 1'b0;
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         otg_data_oe  <= 1'b0;
         otg_addr     <= 2'd0;
         otg_data_out <= 16'd0;
         readdata     <= 32'd0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         op_wr_r     <= op_wr_nxt_s;
         otg_cs_n    <= cs_n_nxt_s;
         otg_rd_n    <= rd_n_nxt_s;
         otg_wr_n    <= wr_n_nxt_s;
         otg_data_oe <= oe_nxt_s;
         if (latch_s) begin
            otg_addr     <= address;
            otg_data_out <= writedata[15:0];
         end
         if (capture_s) begin
            readdata <= {16'd0, otg_data_in};
         end
      end
   end

   // Two-flop synchroniser for the asynchronous HPI interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_meta_r <= 1'b0;
         irq        <= 1'b0;
      end else begin
         int_meta_r <= otg_int;
         irq        <= int_meta_r;
      end
   end

endmodule

// File: tb/tb_otg_hpi_master.sv
module tb_otg_hpi_master;

   localparam int S   = 1;
   localparam int ST  = 2;
   localparam int H   = 1;
   localparam int R   = 2;
   localparam int LAT = 1 + S + ST + H + R;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect, chipselect2, read, write;
   logic [31:0] writedata;
   logic [31:0] readdata, readdata2;
   logic        waitrequest, waitrequest2, irq, irq2;
   logic [1:0]  otg_addr, otg_addr2;
   logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe;
   logic        otg_cs_n2, otg_rd_n2, otg_wr_n2, otg_data_oe2;
   logic [15:0] otg_data_out, otg_data_out2, otg_data_in;
   logic        otg_int;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] rd_model;

   always #5 clk = ~clk;

   otg_hpi_master dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read(read), .write(write), .writedata(writedata), .readdata(readdata),
      .waitrequest(waitrequest), .irq(irq), .otg_addr(otg_addr),
      .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
      .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe),
      .otg_data_in(otg_data_in), .otg_int(otg_int)
   );

   otg_hpi_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(1), .RECOVER_CYC(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect2),
      .read(read), .write(write), .writedata(writedata), .readdata(readdata2),
      .waitrequest(waitrequest2), .irq(irq2), .otg_addr(otg_addr2),
      .otg_cs_n(otg_cs_n2), .otg_rd_n(otg_rd_n2), .otg_wr_n(otg_wr_n2),
      .otg_data_out(otg_data_out2), .otg_data_oe(otg_data_oe2),
      .otg_data_in(otg_data_in), .otg_int(otg_int)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One Avalon access; k counts clocks from the IDLE clock that sees the request.
   task automatic access(input logic wr, input logic rd, input logic [1:0] a,
                         input logic [31:0] wd, input logic [15:0] din, input logic rel);
      logic        act, strb;
      logic [31:0] rd_exp;
      chipselect  = 1'b1;
      write       = wr;
      read        = rd;
      address     = a;
      writedata   = wd;
      otg_data_in = din;
      for (int k = 0; k <= LAT; k++) begin
         @(negedge clk);
         act    = (k >= 1) && (k <= S + ST + H);
         strb   = (k >= S + 1) && (k <= S + ST);
         rd_exp = (!wr && k > S + ST) ? {16'd0, din} : rd_model;
         chk("waitrequest", {31'd0, waitrequest}, {31'd0, (k != LAT)});
         chk("cs_n", {31'd0, otg_cs_n}, {31'd0, !act});
         chk("rd_n", {31'd0, otg_rd_n}, {31'd0, !(strb && !wr)});
         chk("wr_n", {31'd0, otg_wr_n}, {31'd0, !(strb && wr)});
         chk("oe", {31'd0, otg_data_oe}, {31'd0, act && wr});
         if (act) chk("addr", {30'd0, otg_addr}, {30'd0, a});
         if (act && wr) chk("data_out", {16'd0, otg_data_out}, {16'd0, wd[15:0]});
         chk("readdata", readdata, rd_exp);
         if (k < LAT) begin
            @(posedge clk);
            #1;
         end
      end
      if (!wr) rd_model = {16'd0, din};
      @(posedge clk);
      #1;
      if (rel) begin
         chipselect = 1'b0;
         read       = 1'b0;
         write      = 1'b0;
      end
   endtask

   initial begin : main
      logic        hist [0:23];
      logic        w, r, found;
      int          n, csl, rdl;

      reset_n     = 1'b0;
      address     = 2'd0;
      chipselect  = 1'b0;
      chipselect2 = 1'b0;
      read        = 1'b0;
      write       = 1'b0;
      writedata   = 32'd0;
      otg_data_in = 16'd0;
      otg_int     = 1'b0;
      rd_model    = 32'd0;

      // Reset values
      #12;
      chk("rst_cs_n", {31'd0, otg_cs_n}, 32'd1);
      chk("rst_rd_n", {31'd0, otg_rd_n}, 32'd1);
      chk("rst_wr_n", {31'd0, otg_wr_n}, 32'd1);
      chk("rst_oe", {31'd0, otg_data_oe}, 32'd0);
      chk("rst_addr", {30'd0, otg_addr}, 32'd0);
      chk("rst_data_out", {16'd0, otg_data_out}, 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_waitrequest", {31'd0, waitrequest}, 32'd0);
      #10;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed accesses
      access(1'b1, 1'b0, 2'd2, 32'h0000_1234, 16'h0000, 1'b1);
      access(1'b0, 1'b1, 2'd0, 32'h0000_0000, 16'hBEEF, 1'b1);
      chk("read_beef", readdata, 32'h0000_BEEF);
      access(1'b1, 1'b0, 2'd3, 32'hDEAD_7788, 16'h0000, 1'b0);
      access(1'b0, 1'b1, 2'd1, 32'h0000_0000, 16'hA5C3, 1'b1);
      access(1'b1, 1'b1, 2'd1, 32'h0000_55AA, 16'h1111, 1'b1);
      chk("both_kept", readdata, 32'h0000_A5C3);

      // Randomized accesses
      for (int i = 0; i < 24; i++) begin
         w = 1'($urandom);
         r = 1'($urandom);
         if (!w && !r) r = 1'b1;
         access(w, r, 2'($urandom), $urandom, 16'($urandom), 1'($urandom));
      end
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      @(posedge clk);
      #1;

      // Reset in the middle of a write strobe
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 2'd3;
      writedata  = 32'h0000_C0DE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_wr_n", {31'd0, otg_wr_n}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_cs_n", {31'd0, otg_cs_n}, 32'd1);
      chk("mid_rst_wr_n", {31'd0, otg_wr_n}, 32'd1);
      chk("mid_rst_oe", {31'd0, otg_data_oe}, 32'd0);
      chk("mid_rst_readdata", readdata, 32'd0);
      rd_model   = 32'd0;
      chipselect = 1'b0;
      write      = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_cs_n_2", {31'd0, otg_cs_n}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      access(1'b0, 1'b1, 2'd2, 32'd0, 16'h4321, 1'b1);

      // Interrupt synchroniser: irq follows otg_int two clocks later
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1;
         hist[i] = (i == 3) ? 1'b1 : ((i == 2) ? 1'b0 : 1'($urandom));
         otg_int = hist[i];
         @(negedge clk);
         if (i >= 2) chk("irq", {31'd0, irq}, {31'd0, hist[i-2]});
      end
      otg_int = 1'b0;

      // Longer setup/strobe instance: 12 clocks per access
      @(posedge clk);
      #1;
      chipselect2 = 1'b1;
      read        = 1'b1;
      otg_data_in = 16'h6A6A;
      n = 0; csl = 0; rdl = 0; found = 1'b0;
      while (n < 60 && !found) begin
         @(negedge clk);
         if (!otg_cs_n2) csl++;
         if (!otg_rd_n2) rdl++;
         if (!waitrequest2) begin
            found = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("dut2_done_seen", {31'd0, found}, 32'd1);
      chk("dut2_latency", n, 32'd11);
      chk("dut2_cs_low_clks", csl, 32'd8);
      chk("dut2_rd_low_clks", rdl, 32'd4);
      chk("dut2_readdata", readdata2, 32'h0000_6A6A);
      @(posedge clk);
      #1;
      chipselect2 = 1'b0;
      read        = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
